serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor; time-shared across all bit positions by the controller.
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b, LSB first, one bit per clock through a single subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] res_sh;
   logic [WIDTH-1:0] res_nxt;
   logic             bor_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             cell_d, cell_bout;
   logic             last_bit;

   full_subtractor_cell u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (bor_q),
      .diff (cell_d),
      .bout (cell_bout)
   );

   // The result register holds WIDTH-1 bits; the final bit joins it on the last edge.
   assign res_nxt  = {cell_d, res_sh};
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb_q, b_msb_q, ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         bor_q    <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start) begin
               a_sh    <= a;
               b_sh    <= b;
               res_sh  <= '0;
               bor_q   <= 1'b0;
               cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
               // Operand sign bits are shifted out, so keep copies for overflow.
               a_msb_q <= a[WIDTH-1];
               b_msb_q <= b[WIDTH-1];
`endif
            end
            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nxt[WIDTH-1:1];
               bor_q  <= cell_bout;
               cnt_q  <= cnt_q + CW'(1);
               if (last_bit) begin
                  diff_q   <= res_nxt;
                  borrow_q <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q    <= (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and randomized checks of serial_sub_ctrl against an arithmetic reference.
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W-1:0] ref_diff(input int x, input int y);
      return W'((x - y + (1 << W)) % (1 << W));
   endfunction

   function automatic logic ref_borrow(input int x, input int y);
      return x < y;
   endfunction

   function automatic logic ref_ovf(input int x, input int y);
      int sx, sy, r;
      sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
      sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
      r  = sx - sy;
      return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
   endfunction

   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input bit noisy);
      logic [W-1:0] ed;
      ed = ref_diff(int'(op_a), int'(op_b));
      @(negedge clk);
      start = 1'b1; a = op_a; b = op_b;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         check("busy_shift", {30'b0, busy, done}, 32'h2);
         if (noisy) begin
            a = W'($urandom); b = W'($urandom); start = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("done_pulse", {30'b0, busy, done}, 32'h1);
      check("diff", 32'(diff), 32'(ed));
      check("borrow", 32'(borrow), 32'(ref_borrow(int'(op_a), int'(op_b))));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(ref_ovf(int'(op_a), int'(op_b))));
`endif
      @(posedge clk); #1;
      check("idle_after_done", {30'b0, busy, done}, 32'h0);
      check("diff_hold", 32'(diff), 32'(ed));
   endtask

   initial begin
      int n_done, last_c;
      rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", {28'b0, busy, done, borrow, 1'b0}, 32'h0);
      check("rst_diff", 32'(diff), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'h0);
`endif
      rst_n = 1'b1; start = 1'b0;

      run_op(8'h25, 8'h13, 1'b0);

      // Abort during the third SHIFT cycle; start asserted alongside reset.
      @(negedge clk);
      start = 1'b1; a = 8'h37; b = 8'h11;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      check("abort_busy_done", {30'b0, busy, done}, 32'h0);
      check("abort_diff", 32'(diff), 32'h0);
      check("abort_borrow", 32'(borrow), 32'h0);
      rst_n = 1'b1; start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) n_done++;
      end
      check("abort_no_activity", 32'(n_done), 32'h0);
      run_op(8'h09, 8'h04, 1'b0);

      run_op(8'h05, 8'h0A, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0);
      run_op(8'h80, 8'h01, 1'b0);
      run_op(8'h05, 8'h03, 1'b0);
      run_op(8'h00, 8'hFF, 1'b1);
      run_op(8'h7F, 8'h80, 1'b1);

      // Back-to-back operation with start held high.
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h01;
      n_done = 0; last_c = -1;
      for (int c = 0; c < 35; c++) begin
         @(posedge clk); #1;
         if (done) begin
            n_done++;
            check("b2b_diff", 32'(diff), 32'h0F);
            if (last_c >= 0) check("b2b_period", 32'(c - last_c), 32'(W + 2));
            last_c = c;
         end
      end
      check("b2b_count", 32'(n_done), 32'h3);
      start = 1'b0;
      repeat (W + 2) @(posedge clk);
      #1;
      check("b2b_drained", {30'b0, busy, done}, 32'h0);

      for (int k = 0; k < 20; k++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
